// File: rtl/fgcg_sink.sv
// Tail-end receiver for a fine-grained clock-gated pipeline: captures advanced beats
// into a small FIFO, serves a valid/ready consumer and raises back-pressure early.
module fgcg_sink #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     valid_in,
  input  logic                     clk_en_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     stall_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              beat_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic              arr;
  logic              pop;
  logic              push;
  logic              full;

  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c,
                                                  input logic            do_push,
                                                  input logic            do_pop);
    logic [CNT_W-1:0] n;
    n = c;
    if (do_push && !do_pop)
      n = c + CNT_W'(1);
    else if (do_pop && !do_push)
      n = c - CNT_W'(1);
    return n;
  endfunction

  // A held beat (valid without enable) or a bubble (enable without valid) is not new data.
  assign arr  = valid_in & clk_en_in;
  assign full = (count == CNT_W'(DEPTH));
  assign pop  = out_valid & out_ready;
  assign push = arr & (~full | pop);

  assign out_valid = (count != '0);
  assign out_data  = mem[rp];
  // Driven from registered count only, so upstream controllers see a clean level.
  assign stall_out = ((CNT_W'(DEPTH) - count) <= CNT_W'(STALL_MARGIN));

  always_ff @(posedge clk) begin
    if (rstb) begin
      count    <= '0;
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (push) begin
        wp       <= wp + PTR_W'(1);
        beat_cnt <= beat_cnt + 16'd1;
      end
      if (pop)
        rp <= rp + PTR_W'(1);
      count <= next_count(count, push, pop);
      if (arr && !push)
        overflow <= 1'b1;
    end
  end

  // Payload storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push && !rstb)
      mem[wp] <= data_in;
  end

endmodule

// File: tb/tb_fgcg_sink.sv
// Randomized and directed bench for fgcg_sink with a queue-based reference model
// and a scoreboard monitor that checks every consumer transfer.
module tb_fgcg_sink;

  localparam int DATA_W       = 8;
  localparam int DEPTH        = 4;
  localparam int STALL_MARGIN = 1;
  localparam int CNT_W        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              valid_in = 1'b0;
  logic              clk_en_in = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              stall_out;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [15:0]       beat_cnt;

  always #5 clk = ~clk;

  fgcg_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STALL_MARGIN(STALL_MARGIN)) dut (
    .clk(clk), .rstb(rstb), .valid_in(valid_in), .clk_en_in(clk_en_in),
    .data_in(data_in), .stall_out(stall_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count),
    .overflow(overflow), .beat_cnt(beat_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the FIFO contents as a queue plus occupancy and sticky flags.
  logic [DATA_W-1:0] sb_q[$];
  int m_cnt   = 0;
  bit m_ovf   = 1'b0;
  int m_beats = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    if (!model_on) return;
    chk("count", 32'(count), 32'(m_cnt));
    chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
    chk("stall_out", 32'(stall_out), 32'((DEPTH - m_cnt) <= STALL_MARGIN));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("beat_cnt", 32'(beat_cnt), 32'(m_beats % 65536));
    if (m_cnt != 0 && sb_q.size() != 0)
      chk("head_data", 32'(out_data), 32'(sb_q[0]));
  endtask

  // One cycle: check the state left by the previous edge, then drive the next edge.
  task automatic step(input bit v, input bit e, input logic [DATA_W-1:0] d,
                      input bit rdy, input bit rst);
    bit pop_m;
    bit push_m;
    @(negedge clk);
    check_state();
    valid_in  = v;
    clk_en_in = e;
    data_in   = d;
    out_ready = rdy;
    rstb      = rst;
    if (rst) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      m_beats = 0;
      sb_q.delete();
      model_on = 1'b1;
    end else begin
      pop_m  = (m_cnt != 0) && rdy;
      push_m = v && e && ((m_cnt < DEPTH) || pop_m);
      if (push_m) begin
        sb_q.push_back(d);
        m_beats++;
      end
      if (v && e && !push_m)
        m_ovf = 1'b1;
      m_cnt = m_cnt + int'(push_m) - int'(pop_m);
    end
  endtask

  // Monitor: whenever the DUT will hand over its head at the coming edge, compare it.
  initial begin
    logic [DATA_W-1:0] exp_d;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1 && rstb === 1'b0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got data %0h expected no transfer at %0t", out_data, $time);
        end else begin
          exp_d = sb_q.pop_front();
          chk("pop_data", 32'(out_data), 32'(exp_d));
        end
      end
    end
  end

  initial begin
    // Reset held with arrivals present.
    step(1, 1, 8'hAA, 1, 1);
    step(1, 1, 8'hBB, 1, 1);
    step(1, 1, 8'hCC, 1, 1);
    // Fill without consumer: 0x11..0x44, then 0x55 is dropped.
    step(1, 1, 8'h11, 0, 0);
    step(1, 1, 8'h22, 0, 0);
    step(1, 1, 8'h33, 0, 0);
    step(1, 1, 8'h44, 0, 0);
    step(1, 1, 8'h55, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("beat_cnt_4", 32'(beat_cnt), 32'd4);
    // Full with simultaneous pop and push.
    step(1, 1, 8'h66, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0);
    // Held beats, then bubbles.
    for (int i = 0; i < 3; i++) step(1, 0, 8'h77, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 8'h88, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("ovf_survives", 32'(overflow), 32'd1);
    // Streaming after a fresh reset.
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 8'(i + 1), 1, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("beat_cnt_20", 32'(beat_cnt), 32'd20);
    // Mid-stream reset with arrival and pop in the reset cycle.
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h90 + i), 0, 0);
    step(1, 1, 8'hEE, 1, 1);
    step(0, 0, 8'h00, 0, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_beats", 32'(beat_cnt), 32'd0);
    // Randomized traffic with rare resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
           $urandom_range(0, 149) == 0);
    end
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fgcg_sink.md
# fgcg_sink

Tail-end receiver for a fine-grained clock-gated (FGCG) pipeline. It consumes the `valid`/`clk_en` pair and data from the last gated stage and buffers accepted beats in a small FIFO. It presents them to a standard valid/ready consumer and drives a `stall_out` back-pressure signal so upstream stage controllers freeze before the buffer overflows. It is the downstream counterpart of the per-stage FGCG controller.

## Interface
- `DATA_W`, 8, payload width.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `STALL_MARGIN`, 1, free-entry threshold for stall (0..DEPTH-1); covers in-flight upstream beats.
- `clk`  input  1  sole clock, rising-edge.
- `rstb`  input  1  synchronous, active-high reset.
- `valid_in`  input  1  last stage's valid output.
- `clk_en_in`  input  1  last stage's clock-enable output; stage advanced this cycle.
- `data_in`  input  DATA_W  last stage's payload.
- `stall_out`  output  1  back-pressure to the upstream FGCG controllers.
- `out_valid`  output  1  FIFO head holds a beat.
- `out_ready`  input  1  consumer accepts the head.
- `out_data`  output  DATA_W  FIFO head payload.
- `count`  output  $clog2(DEPTH)+1  occupied entries.
- `overflow`  output  1  sticky: a beat was dropped.
- `beat_cnt`  output  16  total beats accepted, wraps modulo 2^16.

## Operation
- Arrival: `arr = valid_in & clk_en_in`.
  - `valid_in` high with `clk_en_in` low is a held beat and is not re-accepted.
  - `clk_en_in` high with `valid_in` low is a bubble and is ignored.
- Pop: `pop = out_valid & out_ready`.
- Push: `push = arr & (count < DEPTH | pop)`.
  - Arrival when full with no pop: the beat is dropped and `overflow` is set. `overflow` clears only on reset.
- Storage is an array `mem[DEPTH]` with write pointer `wp` and read pointer `rp`.
  - Each pointer is $clog2(DEPTH) bits and wraps DEPTH-1 → 0 naturally.
  - Writes go to `mem[wp]` only on push; `mem` is not reset.
- Count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - push & pop: unchanged, and both pointers advance.
- Full and simultaneous events: when full, push and pop in the same cycle is legal. The head leaves and the new beat takes the freed slot; `count` stays DEPTH.
- Empty and simultaneous events: when empty, `pop` is impossible because `out_valid` is 0. There is no fall-through; an arriving beat is visible the next cycle.
- `out_valid = (count != 0)`; `out_data = mem[rp]`. Both are combinational from state.
- `stall_out = (DEPTH - count) <= STALL_MARGIN`. This is combinational from the registered `count`, so it is glitch-free relative to inputs.
- `beat_cnt` increments on every push.

## Timing
- Reset (`rstb` high at a rising edge) forces the following on that edge, regardless of other inputs:
  - `count`=0, `wp`=`rp`=0, `overflow`=0, `beat_cnt`=0.
  - Hence `out_valid`=0 and `stall_out`=0.
- Reset mid-operation discards all buffered beats. Any arrival or pop in the reset cycle is ignored.
- Latency: a beat arriving at edge N shows `out_valid`=1 and `out_data` after edge N. That is 1 cycle from the stage's clock-enabled edge to consumer visibility.
- Consumer handshake:
  - The head transfers on each edge where `out_valid & out_ready`.
  - `out_data` is stable while `out_valid` is high and `out_ready` is low.
- Stall:
  - `stall_out` asserts in the cycle after the push that brings free entries to ≤ STALL_MARGIN.
  - It deasserts in the cycle after the pop that raises free entries above STALL_MARGIN.
- Throughput: one beat per cycle in and out, sustained indefinitely when the consumer is always ready.

## Test plan
- Reset, then hold `rstb`=1 for 2 cycles with `arr`=1. Required: `count`=0, `out_valid`=0, `stall_out`=0, `overflow`=0, `beat_cnt`=0.
- DEPTH=4, STALL_MARGIN=1, `out_ready`=0, push data 0x11, 0x22, 0x33 on consecutive edges.
  - Required: `count` steps 1, 2, 3.
  - `stall_out` rises after the third push.
  - `out_data`=0x11 throughout.
- Continue with a fourth push 0x44 (count=4), then a fifth push 0x55 with `out_ready`=0.
  - Required: 0x55 dropped, `overflow`=1 sticky, `count`=4, `beat_cnt`=4.
- Full FIFO, `out_ready`=1, push 0x66 on the same edge.
  - Required: 0x11 popped, `count` stays 4.
  - Drain order is 0x22, 0x33, 0x44, 0x66, with pointer wrap exercised.
- Held and bubble filtering: `valid_in`=1, `clk_en_in`=0 for 3 cycles; then `valid_in`=0, `clk_en_in`=1 for 2 cycles.
  - Required: no pushes, `beat_cnt` unchanged.
- Streaming: 20 consecutive arrivals of incrementing data with `out_ready`=1.
  - Required: output order matches input, `count` ≤ 1, `stall_out` never asserts, `beat_cnt`=20.
  - Then assert `rstb` mid-stream. Required: all state cleared on that edge.
